alu_op_sequencer: RTL

//   Issue side of the ALU interface. Accepts decoded instruction fields and operands

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_op_decode.sv | 50 +++++
 rtl/alu_op_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue path: ALU function codes, instruction
// opcodes/funct3 values, sequencer states and flag bit positions.
package alu_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b100;
   localparam logic [2:0] ALU_MUL  = 3'b101;
   localparam logic [2:0] ALU_ANDL = 3'b110;
   localparam logic [2:0] ALU_ORL  = 3'b111;

   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [2:0] CUST_MAC    = 3'b000;
   localparam logic [2:0] CUST_ANDL   = 3'b001;
   localparam logic [2:0] CUST_ORL    = 3'b010;
   localparam logic [2:0] CUST_SLEEP  = 3'b110;
   localparam logic [2:0] CUST_WAKEUP = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MAC2,
      ST_HOLD,
      ST_SLEEP,
      ST_WAKE
   } state_t;

   // Positions within the {zero,negative,carry,overflow} flag vector
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: maps opcode/funct3/funct7b5 onto a 3-bit ALU
// function plus the MAC/SLEEP/WAKEUP/illegal qualifiers handled by the sequencer.
import alu_pkg::*;

module alu_op_decode (
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   output logic [2:0] o_code,
   output logic       o_is_mac,
   output logic       o_is_sleep,
   output logic       o_is_wake,
   output logic       o_illegal
);

   always_comb begin
      o_code     = ALU_ADD;
      o_is_mac   = 1'b0;
      o_is_sleep = 1'b0;
      o_is_wake  = 1'b0;
      o_illegal  = 1'b0;
      case (i_opcode)
         OPC_OP, OPC_OPIMM: begin
            case (i_funct3)
               // Immediate form has no subtract; bit 30 is part of the immediate there
               F3_ADD:  o_code = (i_opcode == OPC_OP && i_funct7b5) ? ALU_SUB : ALU_ADD;
               F3_AND:  o_code = ALU_AND;
               F3_OR:   o_code = ALU_OR;
               F3_SLT:  o_code = ALU_SLT;
               default: o_illegal = 1'b1;
            endcase
         end
         OPC_CUSTOM0: begin
            case (i_funct3)
               CUST_MAC: begin
                  o_code   = ALU_MUL;
                  o_is_mac = 1'b1;
               end
               CUST_ANDL:   o_code     = ALU_ANDL;
               CUST_ORL:    o_code     = ALU_ORL;
               CUST_SLEEP:  o_is_sleep = 1'b1;
               CUST_WAKEUP: o_is_wake  = 1'b1;
               default:     o_illegal  = 1'b1;
            endcase
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue side of the ALU: accepts decoded ops, drives the ALU (two passes for MAC),
// registers result/flags for a downstream handshake and runs the sleep/wake FSM.
import alu_pkg::*;

module alu_op_sequencer #(
   parameter int XLEN        = 32,
   parameter int WAKE_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7b5,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_acc,
   input  logic            wake_irq,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [2:0]      alu_f,
   input  logic [XLEN-1:0] alu_result,
   input  logic [3:0]      alu_flags,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [3:0]      out_flags,
   output logic            out_illegal,
   output logic            sleep_o
);

   localparam int CW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_wake_pend;
   logic [XLEN-1:0] r_result;
   logic [3:0]      r_flags;
   logic            r_illegal;

   logic [XLEN-1:0] r_rs1, r_rs2, r_acc, r_prod;
   logic [2:0]      r_op_code;
   logic            r_op_mac, r_op_sleep, r_op_wake, r_op_ill;

   logic [2:0]      w_dec_code;
   logic            w_dec_mac, w_dec_sleep, w_dec_wake, w_dec_ill;
   logic            w_in_ready;
   logic            w_accept;

   alu_op_decode u_decode (
      .i_opcode   (in_opcode),
      .i_funct3   (in_funct3),
      .i_funct7b5 (in_funct7b5),
      .o_code     (w_dec_code),
      .o_is_mac   (w_dec_mac),
      .o_is_sleep (w_dec_sleep),
      .o_is_wake  (w_dec_wake),
      .o_illegal  (w_dec_ill)
   );

   // While asleep only a WAKEUP may be accepted; HOLD passes out_ready through
   always_comb begin
      w_in_ready = 1'b0;
      case (r_state)
         ST_IDLE:  w_in_ready = 1'b1;
         ST_HOLD:  w_in_ready = out_ready & ~r_op_sleep;
         ST_SLEEP: w_in_ready = w_dec_wake;
         default:  w_in_ready = 1'b0;
      endcase
   end

   assign w_accept = in_valid & w_in_ready;

   always_comb begin
      alu_a = '0;
      alu_b = '0;
      alu_f = ALU_ADD;
      case (r_state)
         ST_EXEC: begin
            alu_a = r_rs1;
            alu_b = r_rs2;
            alu_f = r_op_code;
         end
         ST_MAC2: begin
            alu_a = r_prod;
            alu_b = r_acc;
         end
         default: ;
      endcase
   end

   // Operand/decode latches and the MAC product carry no reset: they are only
   // consumed in states that can be reached after an accept or an EXEC pass.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_rs1      <= in_rs1;
         r_rs2      <= in_rs2;
         r_acc      <= in_acc;
         r_op_code  <= w_dec_code;
         r_op_mac   <= w_dec_mac;
         r_op_sleep <= w_dec_sleep;
         r_op_wake  <= w_dec_wake;
         r_op_ill   <= w_dec_ill;
      end
      if (r_state == ST_EXEC) r_prod <= alu_result;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_wake_pend <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
         r_illegal   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_accept) r_state <= ST_EXEC;
            ST_EXEC: begin
               if (r_op_mac) begin
                  r_state <= ST_MAC2;
               end else begin
                  r_state   <= ST_HOLD;
                  r_illegal <= r_op_ill;
                  if (r_op_ill || r_op_sleep) begin
                     r_result <= '0;
                     r_flags  <= '0;
                  end else if (r_op_wake) begin
                     r_result <= r_rs1;
                     r_flags  <= '0;
                  end else begin
                     r_result <= alu_result;
                     r_flags  <= alu_flags;
                  end
               end
            end
            ST_MAC2: begin
               r_state   <= ST_HOLD;
               r_result  <= alu_result;
               r_flags   <= alu_flags;
               r_illegal <= 1'b0;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  if (r_op_sleep)    r_state <= ST_SLEEP;
                  else if (in_valid) r_state <= ST_EXEC;
                  else               r_state <= ST_IDLE;
               end
            end
            ST_SLEEP: begin
               // An accepted WAKEUP wins over a simultaneous wake_irq and is replayed
               if (w_accept || wake_irq) begin
                  r_cnt       <= CW'(WAKE_CYCLES - 1);
                  r_wake_pend <= w_accept;
                  r_state     <= ST_WAKE;
               end
            end
            ST_WAKE: begin
               if (r_cnt == '0) r_state <= r_wake_pend ? ST_EXEC : ST_IDLE;
               else             r_cnt   <= r_cnt - CW'(1);
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = (r_state == ST_HOLD);
   assign sleep_o     = (r_state == ST_SLEEP);
   assign out_result  = r_result;
   assign out_flags   = r_flags;
   assign out_illegal = r_illegal;

endmodule
